// File: rtl/pll_rst_seq.sv
// PLL bring-up and staged reset-release sequencer: pulses the PLL reset, waits for a stable lock,
// then releases the sdram-domain reset followed by the wishbone-domain reset.
module pll_rst_seq #(
    parameter int unsigned ARESET_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT  = 65536,
    parameter int unsigned LOCK_STABLE   = 256,
    parameter int unsigned STAGE_DELAY   = 64,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       pll_locked_i,
    input  logic       sw_reset_i,
    output logic       pll_areset_o,
    output logic       sdram_rst_o,
    output logic       wb_rst_o,
    output logic [2:0] state_o,
    output logic [3:0] retry_o,
    output logic [7:0] lock_loss_o,
    output logic       fail_o
);

    localparam int unsigned MAX_AB  = (ARESET_CYCLES > LOCK_TIMEOUT) ? ARESET_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned MAX_CD  = (LOCK_STABLE > STAGE_DELAY) ? LOCK_STABLE : STAGE_DELAY;
    localparam int unsigned CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        REL_SDRAM = 3'd3,
        RUN       = 3'd4,
        FAIL      = 3'd5
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    retry_q, retry_d;
    logic [7:0]    loss_q, loss_d;
    logic          sync1_q, sync2_q;
    logic          areset_q, areset_d;
    logic          sdram_q, sdram_d;
    logic          wb_q, wb_d;
    logic          fail_q, fail_d;
    logic          enter;
    logic          lock_s;

    assign lock_s = sync2_q;

    // State register, synchronizer and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= RESET_PLL;
            cnt_q    <= '0;
            retry_q  <= '0;
            loss_q   <= '0;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            areset_q <= 1'b1;
            sdram_q  <= 1'b1;
            wb_q     <= 1'b1;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            retry_q  <= retry_d;
            loss_q   <= loss_d;
            sync1_q  <= pll_locked_i;
            sync2_q  <= sync1_q;
            areset_q <= areset_d;
            sdram_q  <= sdram_d;
            wb_q     <= wb_d;
            fail_q   <= fail_d;
        end
    end

    // Next state; a software request re-enters RESET_PLL even from RESET_PLL, restarting the pulse
    always_comb begin
        state_d = state_q;
        enter   = 1'b0;
        retry_d = retry_q;
        loss_d  = loss_q;
        if (sw_reset_i) begin
            state_d = RESET_PLL;
            enter   = 1'b1;
            retry_d = '0;
        end else begin
            case (state_q)
                RESET_PLL: begin
                    if (cnt_q == CW'(ARESET_CYCLES - 1)) begin
                        state_d = WAIT_LOCK;
                        enter   = 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = STABLE;
                        enter   = 1'b1;
                    end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                        enter = 1'b1;
                        if (retry_q < 4'(MAX_RETRIES)) begin
                            state_d = RESET_PLL;
                            retry_d = retry_q + 4'd1;
                        end else begin
                            state_d = FAIL;
                        end
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        state_d = WAIT_LOCK;
                        enter   = 1'b1;
                    end else if (cnt_q == CW'(LOCK_STABLE - 1)) begin
                        state_d = REL_SDRAM;
                        enter   = 1'b1;
                    end
                end
                REL_SDRAM: begin
                    if (!lock_s) begin
                        state_d = RESET_PLL;
                        enter   = 1'b1;
                    end else if (cnt_q == CW'(STAGE_DELAY - 1)) begin
                        state_d = RUN;
                        enter   = 1'b1;
                        retry_d = '0;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state_d = RESET_PLL;
                        enter   = 1'b1;
                        if (loss_q != '1) loss_d = loss_q + 8'd1;
                    end
                end
                FAIL: begin
                    state_d = FAIL;
                end
                default: begin
                    state_d = RESET_PLL;
                    enter   = 1'b1;
                end
            endcase
        end
        cnt_d = enter ? '0 : cnt_q + CW'(1);
    end

    // Outputs decoded from the next state so the registered copies line up with state_q
    always_comb begin
        areset_d = (state_d == RESET_PLL) || (state_d == FAIL);
        sdram_d  = !((state_d == REL_SDRAM) || (state_d == RUN));
        wb_d     = (state_d != RUN);
        fail_d   = (state_d == FAIL);
    end

    assign pll_areset_o = areset_q;
    assign sdram_rst_o  = sdram_q;
    assign wb_rst_o     = wb_q;
    assign state_o      = state_q;
    assign retry_o      = retry_q;
    assign lock_loss_o  = loss_q;
    assign fail_o       = fail_q;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Bench for pll_rst_seq: directed vector table, hand-written corner sequences and randomized lock
// behaviour, all checked against a timestamp-based model of the sequencing rules.
module tb_pll_rst_seq;

    localparam int AR = 4;
    localparam int TO = 32;
    localparam int LS = 8;
    localparam int SD = 4;
    localparam int MR = 2;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       sw_reset_i = 1'b0;
    logic       pll_locked_i = 1'b0;
    logic       pll_areset_o, sdram_rst_o, wb_rst_o, fail_o;
    logic [2:0] state_o;
    logic [3:0] retry_o;
    logic [7:0] lock_loss_o;

    always #5 clk = ~clk;

    pll_rst_seq #(
        .ARESET_CYCLES(AR),
        .LOCK_TIMEOUT (TO),
        .LOCK_STABLE  (LS),
        .STAGE_DELAY  (SD),
        .MAX_RETRIES  (MR)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .pll_locked_i(pll_locked_i),
        .sw_reset_i  (sw_reset_i),
        .pll_areset_o(pll_areset_o),
        .sdram_rst_o (sdram_rst_o),
        .wb_rst_o    (wb_rst_o),
        .state_o     (state_o),
        .retry_o     (retry_o),
        .lock_loss_o (lock_loss_o),
        .fail_o      (fail_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: phase number, edge index at which the phase was entered, and lock history
    int m_st = 0, m_entry = 0, m_rt = 0, m_ll = 0, m_cyc = 0;
    bit m_s1 = 1'b0, m_s2 = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %0d, want %0d", name, m_cyc, act, exp);
        end
    endtask

    task automatic go(input int s);
        m_st    = s;
        m_entry = m_cyc;
    endtask

    task automatic model_edge();
        bit ls;
        int n;
        m_cyc++;
        ls = m_s2;
        if (rst_i) begin
            m_st = 0; m_entry = m_cyc; m_rt = 0; m_ll = 0; m_s1 = 1'b0; m_s2 = 1'b0;
            return;
        end
        m_s2 = m_s1;
        m_s1 = pll_locked_i;
        n = m_cyc - m_entry;
        if (sw_reset_i) begin
            go(0);
            m_rt = 0;
        end else begin
            case (m_st)
                0: if (n == AR) go(1);
                1: if (ls) go(2);
                   else if (n == TO) begin
                       if (m_rt < MR) begin m_rt++; go(0); end
                       else go(5);
                   end
                2: if (!ls) go(1); else if (n == LS) go(3);
                3: if (!ls) go(0); else if (n == SD) begin go(4); m_rt = 0; end
                4: if (!ls) begin go(0); if (m_ll < 255) m_ll++; end
                default: ;
            endcase
        end
    endtask

    task automatic check_model();
        chk("m_state", int'(state_o), m_st);
        chk("m_pll_areset", int'(pll_areset_o), int'(m_st == 0 || m_st == 5));
        chk("m_sdram_rst", int'(sdram_rst_o), int'(!(m_st == 3 || m_st == 4)));
        chk("m_wb_rst", int'(wb_rst_o), int'(m_st != 4));
        chk("m_retry", int'(retry_o), m_rt);
        chk("m_lock_loss", int'(lock_loss_o), m_ll);
        chk("m_fail", int'(fail_o), int'(m_st == 5));
        chk("m_order", int'(!wb_rst_o && sdram_rst_o), 0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    typedef struct {
        int rst, sw, lk, n;
        int st, ar, sd, wb, rt, ll, fl;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int rst, input int sw, input int lk, input int n,
                                input int st, input int ar, input int sd, input int wb,
                                input int rt, input int ll, input int fl);
        vec_t v;
        v.rst = rst; v.sw = sw; v.lk = lk; v.n = n;
        v.st = st; v.ar = ar; v.sd = sd; v.wb = wb; v.rt = rt; v.ll = ll; v.fl = fl;
        return v;
    endfunction

    initial begin
        int ar_cnt, prev_st, prev_sd, fall_cyc, dly, got;
        int ent_cyc[$];
        vec_t v;

        // Bring-up, lock loss in RUN, re-lock, then rst_i beating sw_reset_i
        tbl.push_back(mk(1, 0, 0, 3,  0, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 3,  0, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1,  1, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 6,  1, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 2,  1, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1,  2, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 7,  2, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1,  3, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 3,  3, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1,  4, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 2,  4, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1,  0, 1, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 3,  0, 1, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1,  1, 0, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1,  2, 0, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 7,  2, 0, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1,  3, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 3,  3, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1,  4, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 1, 1,  0, 1, 1, 1, 0, 0, 0));

        foreach (tbl[i]) begin
            v = tbl[i];
            rst_i        = (v.rst != 0);
            sw_reset_i   = (v.sw != 0);
            pll_locked_i = (v.lk != 0);
            run(v.n);
            chk($sformatf("vec%0d_state", i), int'(state_o), v.st);
            chk($sformatf("vec%0d_areset", i), int'(pll_areset_o), v.ar);
            chk($sformatf("vec%0d_sdram", i), int'(sdram_rst_o), v.sd);
            chk($sformatf("vec%0d_wb", i), int'(wb_rst_o), v.wb);
            chk($sformatf("vec%0d_retry", i), int'(retry_o), v.rt);
            chk($sformatf("vec%0d_loss", i), int'(lock_loss_o), v.ll);
            chk($sformatf("vec%0d_fail", i), int'(fail_o), v.fl);
        end
        sw_reset_i = 1'b0;

        // No lock ever: three areset pulses, then FAIL
        rst_i = 1'b1; pll_locked_i = 1'b0; run(2);
        rst_i = 1'b0;
        ar_cnt = 0;
        for (int i = 0; i < 3 * (AR + TO) - 1; i++) begin
            step();
            if (pll_areset_o) ar_cnt++;
        end
        // the first pulse's opening cycle precedes the loop
        chk("nolock_areset_cycles", ar_cnt, 3 * AR - 1);
        chk("nolock_state_before", int'(state_o), 1);
        chk("nolock_retry_before", int'(retry_o), MR);
        step();
        chk("nolock_state", int'(state_o), 5);
        chk("nolock_fail", int'(fail_o), 1);
        chk("nolock_retry", int'(retry_o), MR);
        chk("nolock_resets", int'({pll_areset_o, sdram_rst_o, wb_rst_o}), 7);
        run(5);
        chk("nolock_stays_fail", int'(state_o), 5);

        sw_reset_i = 1'b1; step(); sw_reset_i = 1'b0;
        chk("swrst_state", int'(state_o), 0);
        chk("swrst_fail", int'(fail_o), 0);
        chk("swrst_retry", int'(retry_o), 0);

        // Lock glitch inside STABLE
        rst_i = 1'b1; run(2); rst_i = 1'b0; pll_locked_i = 1'b0; run(5);
        prev_st = int'(state_o); prev_sd = int'(sdram_rst_o); fall_cyc = -1;
        for (int k = 0; k < 40; k++) begin
            pll_locked_i = (k != 5);
            step();
            if (state_o == 3'd2 && prev_st != 2) ent_cyc.push_back(m_cyc);
            if (!sdram_rst_o && prev_sd != 0 && fall_cyc < 0) fall_cyc = m_cyc;
            prev_st = int'(state_o);
            prev_sd = int'(sdram_rst_o);
        end
        chk("glitch_stable_entries", ent_cyc.size(), 2);
        dly = (ent_cyc.size() >= 2 && fall_cyc >= 0) ? fall_cyc - ent_cyc[1] : -1;
        chk("glitch_sdram_delay", dly, LS);
        chk("glitch_retry", int'(retry_o), 0);

        // rst_i one cycle after sdram release
        rst_i = 1'b1; run(2); rst_i = 1'b0; pll_locked_i = 1'b1;
        got = 0;
        for (int i = 0; i < 100 && got == 0; i++) begin
            step();
            if (!sdram_rst_o) got = 1;
        end
        chk("midrel_sdram_fell", got, 1);
        step();
        rst_i = 1'b1; step(); rst_i = 1'b0;
        chk("midrel_state", int'(state_o), 0);
        chk("midrel_resets", int'({pll_areset_o, sdram_rst_o, wb_rst_o}), 7);

        // Randomized lock behaviour with occasional sw_reset_i and rst_i
        for (int b = 0; b < 120; b++) begin
            int hold;
            pll_locked_i = ($urandom_range(0, 3) != 0);
            hold = ($urandom_range(0, 7) == 0) ? $urandom_range(60, 150) : $urandom_range(1, 40);
            for (int c = 0; c < hold; c++) begin
                sw_reset_i = ($urandom_range(0, 199) == 0);
                rst_i      = ($urandom_range(0, 399) == 0);
                step();
            end
        end
        sw_reset_i = 1'b0;
        rst_i      = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
